// File: rtl/macc_requant.sv
// macc_requant: accumulates macc partial sums, adds bias, scales, rounds, saturates to int8 into an output FIFO.
// Optional `MACC_REQUANT_RELU_EN clamps negative results to zero before saturation.
module macc_requant #(
    parameter int IN_WIDTH   = 19,
    parameter int ACC_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IN_WIDTH-1:0] i_data,
    input  logic                i_valid,
    input  logic                i_last,
    input  logic [31:0]         i_bias,
    input  logic [15:0]         i_scale,
    input  logic [4:0]          i_shift,
    output logic [7:0]          o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_overflow
);
    localparam int PW = ACC_WIDTH + 17;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic signed [PW-1:0] SAT_MAX = 127;
    localparam logic signed [PW-1:0] SAT_MIN = -128;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d, base, ext;
    logic                   s1_valid_q, s1_valid_d;
    logic [ACC_WIDTH-1:0]   s1_sum_q, s1_sum_d;
    logic [15:0]            s1_scale_q, s1_scale_d;
    logic [4:0]             s1_shift_q, s1_shift_d;
    logic                   s2_valid_q, s2_valid_d;
    logic signed [PW-1:0]   s2_prod_q, s2_prod_d;
    logic [4:0]             s2_shift_q, s2_shift_d;
    logic                   s3_valid_q, s3_valid_d;
    logic [7:0]             s3_data_q, s3_data_d;
    logic signed [PW-1:0]   rnd, r;
    logic [AW:0]            wr_q, wr_d, rd_q, rd_d;
    logic                   ovf_q, ovf_d;
    logic                   empty, full, pop, push_ok;
    logic [7:0]             mem_q [FIFO_DEPTH];

    always_comb begin
        base       = (state_q == ACCUM) ? acc_q : '0;
        ext        = {{(ACC_WIDTH-IN_WIDTH){i_data[IN_WIDTH-1]}}, i_data};
        state_d    = state_q;
        acc_d      = acc_q;
        s1_valid_d = i_valid & i_last;
        s1_sum_d   = s1_sum_q;
        s1_scale_d = s1_scale_q;
        s1_shift_d = s1_shift_q;
        if (i_valid && i_last) begin
            s1_sum_d   = base + ext + ACC_WIDTH'($signed(i_bias));
            s1_scale_d = i_scale;
            s1_shift_d = i_shift;
            acc_d      = '0;
            state_d    = IDLE;
        end else if (i_valid) begin
            acc_d   = base + ext;
            state_d = ACCUM;
        end
        s2_valid_d = s1_valid_q;
        s2_prod_d  = $signed(s1_sum_q) * $signed({1'b0, s1_scale_q});
        s2_shift_d = s1_shift_q;
        // Round half up: bias by half an LSB of the shifted result, then floor-shift.
        rnd        = (s2_shift_q == 5'd0) ? '0 : PW'(1) << (s2_shift_q - 5'd1);
        r          = (s2_prod_q + rnd) >>> s2_shift_q;
        s3_valid_d = s2_valid_q;
`ifdef MACC_REQUANT_RELU_EN
        s3_data_d  = (r < 0) ? 8'h00 : (r > SAT_MAX) ? 8'h7f : r[7:0];
`else
        s3_data_d  = (r > SAT_MAX) ? 8'h7f : (r < SAT_MIN) ? 8'h80 : r[7:0];
`endif
        empty      = (wr_q == rd_q);
        full       = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop        = !empty && i_ready;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        push_ok    = s3_valid_q && (!full || pop);
        wr_d       = wr_q + (AW+1)'(push_ok);
        rd_d       = rd_q + (AW+1)'(pop);
        ovf_d      = ovf_q | (s3_valid_q & full & !pop);
        o_valid    = !empty;
        o_data     = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
        o_overflow = ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_scale_q <= '0;
            s1_shift_q <= '0;
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
            s2_shift_q <= '0;
            s3_valid_q <= 1'b0;
            s3_data_q  <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s1_scale_q <= s1_scale_d;
            s1_shift_q <= s1_shift_d;
            s2_valid_q <= s2_valid_d;
            s2_prod_q  <= s2_prod_d;
            s2_shift_q <= s2_shift_d;
            s3_valid_q <= s3_valid_d;
            s3_data_q  <= s3_data_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= s3_data_q;
    end
endmodule

// File: doc/macc_requant.md
MACC_REQUANT -- requirements
Module: macc_requant

Interface
- REQ-001 The module SHALL have parameter IN_WIDTH, default 19, giving the signed width of the upstream macc result (16 + clog2(8)).
- REQ-002 The module SHALL have parameter ACC_WIDTH, default 32, giving the signed accumulator width.
- REQ-003 The module SHALL have parameter FIFO_DEPTH, default 4, giving the number of output result entries (power of two, at least 2).
- REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
- REQ-006 Port i_data, input, IN_WIDTH bits: signed partial sum from macc o_data.
- REQ-007 Port i_valid, input, 1 bit: i_data valid, driven by macc o_valid; there is no input back-pressure.
- REQ-008 Port i_last, input, 1 bit: qualified by i_valid; marks the final partial sum of one output value.
- REQ-009 Port i_bias, input, 32 bits: signed bias, sampled on the i_last beat.
- REQ-010 Port i_scale, input, 16 bits: unsigned multiplier, sampled on the i_last beat.
- REQ-011 Port i_shift, input, 5 bits: right-shift amount 0..31, sampled on the i_last beat.
- REQ-012 Port o_data, output, 8 bits: signed int8 result at the FIFO head.
- REQ-013 Port o_valid, output, 1 bit: high while the FIFO is non-empty.
- REQ-014 Port i_ready, input, 1 bit: downstream accept; an entry pops when o_valid and i_ready are both high.
- REQ-015 Port o_overflow, output, 1 bit: sticky flag indicating a result was dropped.

Function
- REQ-016 The FSM SHALL have two states: IDLE (no pending partials) and ACCUM.
- REQ-017 On i_valid & !i_last, acc SHALL load base + sext(i_data), where base is 0 in IDLE and acc in ACCUM; the FSM then goes to ACCUM.
- REQ-018 On i_valid & i_last, stage 1 SHALL capture sum = base + sext(i_data) + i_bias, together with scale and shift; acc clears and the FSM goes to IDLE.
- REQ-019 Additions into acc and sum SHALL wrap modulo 2^ACC_WIDTH; there is no saturation at this point.
- REQ-020 Stage 2 SHALL compute prod = sum * {1'b0, i_scale} as a signed value, ACC_WIDTH+17 bits wide, with no truncation.
- REQ-021 Stage 3 rounding: r = (prod + 2^(shift-1)) >>> shift, using an arithmetic shift; when shift = 0, r = prod.
- REQ-022 Stage 3 saturation: r is clamped to [-128, 127] and the clamped value is pushed into the FIFO.
- REQ-023 Latency: an i_last beat sampled at edge T SHALL make o_valid high after edge T+3 when the FIFO was empty.
- REQ-024 Throughput: the block SHALL accept an i_last beat every cycle and produce one result per cycle.
- REQ-025 A push when the FIFO is full and there is no simultaneous pop SHALL drop the result and set o_overflow; o_overflow stays set until reset.
- REQ-026 A simultaneous push and pop when full SHALL succeed: occupancy is unchanged and no overflow occurs.
- REQ-027 The FIFO SHALL return results in order; o_data and o_valid SHALL be stable while o_valid is high and i_ready is low.
- REQ-028 i_valid low SHALL leave acc, the FSM and all inputs unconsumed and unchanged.

Reset
- REQ-029 rst_n low SHALL asynchronously force: FSM to IDLE, acc = 0, pipeline valids = 0, FIFO empty, o_valid = 0, o_data = 0, o_overflow = 0.
- REQ-030 A reset asserted mid-accumulation or mid-pipeline SHALL discard all partial and in-flight results.

Configuration
- REQ-031 Macro MACC_REQUANT_RELU_EN, when defined, SHALL force negative r to 0 before saturation, so the output range is [0, 127].
- REQ-032 When MACC_REQUANT_RELU_EN is undefined, the output SHALL be signed in [-128, 127] and no ReLU logic is built.

Verification
- REQ-033 Single beat, i_data=100 with i_last, bias=0, scale=1, shift=0 -> o_data=100, o_valid high 3 cycles after the beat.
- REQ-034 Beats 1000, 2000, -500, 500 (last), bias=24, scale=3, shift=8 -> 9072 rounds to o_data=35.
- REQ-035 Saturation and rounding cases:
  - i_data=-50000 (last), scale=1, shift=0 -> o_data=-128 (0 with RELU_EN).
  - i_data=-3, shift=1 -> o_data=-1.
- REQ-036 Back-pressure: i_ready=0 with 5 single-beat results of values 1..5 -> o_overflow=1; after i_ready=1, outputs are 1, 2, 3, 4 in order and the fifth is lost.
- REQ-037 Reset mid-accumulation: beats 10, 20, then rst_n pulse, then beat 7 (last), scale=1 -> o_data=7.
- REQ-038 Streaming: 8 consecutive last beats 1..8 with i_ready=1 -> 8 consecutive o_valid cycles with o_data 1..8.
